// File: rtl/rule110_sequencer.sv
// rule110_sequencer
//   Command-driven controller for a rule-110 cell array. It loads a seed from a
//   byte stream, steps the external cell datapath at a divided rate, and streams
//   a snapshot of the array back out as bytes.
//
// Handshakes: every stream (cmd, seed, rd) transfers exactly one item on a
//   rising clk edge where valid & ready are both high. A producer holds valid
//   and its payload stable until that edge. Ready may be high without valid.
//
// Ports
//   clk, reset              clock; asynchronous active-high reset
//   cmd_valid/ready/op/arg  command stream (00 LOAD, 01 RUN, 10 READ, 11 STOP)
//   rate                    step period minus one, sampled at divider reload
//   seed_valid/ready/data   seed byte stream, least-significant byte first
//   ca_load, ca_seed        one-cycle load pulse and registered seed value
//   ca_step                 one-cycle pulse: datapath advances one generation
//   ca_state                current cell state from the datapath
//   rd_valid/ready/data     readout byte stream, least-significant byte first
//   rd_last                 high with the final readout byte
//   busy, done              not idle; one-cycle end-of-run pulse
//   gen_count               generations stepped since the last ca_load
//   state_dbg               current FSM state (IDLE=0, LOAD=1, RUN=2, READ=3)
module rule110_sequencer #(
  parameter int NUM_CELLS = 32,
  parameter int GEN_W     = 16,
  parameter int DIV_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [GEN_W-1:0]     cmd_arg,
  input  logic [DIV_W-1:0]     rate,
  input  logic                 seed_valid,
  output logic                 seed_ready,
  input  logic [7:0]           seed_data,
  output logic                 ca_load,
  output logic [NUM_CELLS-1:0] ca_seed,
  output logic                 ca_step,
  input  logic [NUM_CELLS-1:0] ca_state,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [7:0]           rd_data,
  output logic                 rd_last,
  output logic                 busy,
  output logic                 done,
  output logic [GEN_W-1:0]     gen_count,
  output logic [1:0]           state_dbg
);

  localparam int NBYTES = NUM_CELLS / 8;
  localparam int BC_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;
  localparam logic [1:0] OP_STOP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_READ = 2'd3
  } state_t;

  state_t                 state;
  logic [BC_W-1:0]        byte_cnt;
  logic [BC_W-1:0]        rd_cnt;
  logic [NUM_CELLS-1:0]   rd_sr;      // bytes not yet presented on rd_data
  logic [DIV_W-1:0]       div_cnt;
  logic [GEN_W-1:0]       remaining;
  logic                   free_run;
  logic                   finishing;  // final step issued; end the run next edge
  logic                   seed_fire;
  logic [NUM_CELLS-1:0]   seed_next;  // seed register value including this byte

  assign cmd_ready  = (state == ST_IDLE) || (state == ST_RUN);
  assign seed_ready = (state == ST_LOAD);
  assign seed_fire  = seed_ready && seed_valid;
  assign state_dbg  = state;

  // Seed bytes enter at the top and move down, so byte 0 ends at [7:0]. Only
  // the bytes already received are stored; the incoming one completes the word.
  generate
    if (NUM_CELLS > 8) begin : g_seed_sr
      logic [NUM_CELLS-9:0] seed_sr;
      assign seed_next = {seed_data, seed_sr};
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          seed_sr <= '0;
        end else if (seed_fire) begin
          seed_sr <= seed_next[NUM_CELLS-1:8];
        end
      end
    end else begin : g_seed_byte
      assign seed_next = seed_data;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ca_load   <= 1'b0;
      ca_seed   <= '0;
      ca_step   <= 1'b0;
      gen_count <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_last   <= 1'b0;
      rd_sr     <= '0;
      rd_cnt    <= '0;
      byte_cnt  <= '0;
      div_cnt   <= '0;
      remaining <= '0;
      free_run  <= 1'b0;
      finishing <= 1'b0;
    end else begin
      ca_load <= 1'b0;
      ca_step <= 1'b0;
      done    <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_LOAD: begin
                state    <= ST_LOAD;
                busy     <= 1'b1;
                byte_cnt <= '0;
              end
              OP_RUN: begin
                state     <= ST_RUN;
                busy      <= 1'b1;
                free_run  <= (cmd_arg == '0);
                finishing <= 1'b0;
                // The handshake edge counts as the first divider tick, so the
                // first step appears rate+1 cycles after the handshake cycle.
                if (rate == '0) begin
                  ca_step   <= 1'b1;
                  gen_count <= gen_count + GEN_W'(1);
                  div_cnt   <= '0;
                  remaining <= cmd_arg - GEN_W'(1);
                  finishing <= (cmd_arg == GEN_W'(1));
                end else begin
                  div_cnt   <= rate - DIV_W'(1);
                  remaining <= cmd_arg;
                end
              end
              OP_READ: begin
                state    <= ST_READ;
                busy     <= 1'b1;
                rd_valid <= 1'b1;
                rd_data  <= ca_state[7:0];
                rd_sr    <= ca_state >> 8;
                rd_cnt   <= '0;
                rd_last  <= (NBYTES == 1);
              end
              default: ;  // STOP while idle does nothing
            endcase
          end
        end

        ST_LOAD: begin
          if (seed_valid) begin
            if (byte_cnt == BC_W'(NBYTES - 1)) begin
              ca_seed   <= seed_next;
              ca_load   <= 1'b1;
              gen_count <= '0;
              byte_cnt  <= '0;
              state     <= ST_IDLE;
              busy      <= 1'b0;
            end else begin
              byte_cnt <= byte_cnt + BC_W'(1);
            end
          end
        end

        ST_RUN: begin
          // STOP wins over a step due on the same edge; LOAD/READ/RUN are dropped.
          if ((cmd_valid && (cmd_op == OP_STOP)) || finishing) begin
            done      <= 1'b1;
            finishing <= 1'b0;
            state     <= ST_IDLE;
            busy      <= 1'b0;
          end else if (div_cnt == '0) begin
            ca_step   <= 1'b1;
            gen_count <= gen_count + GEN_W'(1);
            div_cnt   <= rate;
            if (!free_run) begin
              remaining <= remaining - GEN_W'(1);
              finishing <= (remaining == GEN_W'(1));
            end
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end

        ST_READ: begin
          if (rd_ready) begin
            if (rd_last) begin
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
              state    <= ST_IDLE;
              busy     <= 1'b0;
            end else begin
              rd_data <= rd_sr[7:0];
              rd_sr   <= rd_sr >> 8;
              rd_cnt  <= rd_cnt + BC_W'(1);
              rd_last <= (rd_cnt == BC_W'(NBYTES - 2));
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
